// File: rtl/debounce_event_pkg.sv
// Shared helpers for the debounce_event input conditioner.
package debounce_event_pkg;

    // Counter width for a divide-by-rate tick; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned rate);
        return (rate <= 1) ? 1 : $clog2(rate);
    endfunction

endpackage

// File: rtl/debounce_event_channel.sv
// One conditioned input bit: synchroniser, sample history, debounced level and edge pulses.
module debounce_event_channel #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned N           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_in,
    output logic o_out,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [N-1:0]           r_hist;
    logic [N-1:0]           w_hist_next;
    logic                   r_out;
    logic                   r_out_d;
    logic                   r_rise;
    logic                   r_fall;

    // History as it will be after this tick, so the level can follow on the Nth sample.
    assign w_hist_next = {r_hist[N-2:0], r_sync[SYNC_STAGES-1]};

    // Synchronise, sample on tick, and flag level changes one cycle after they happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_hist  <= '0;
            r_out   <= 1'b0;
            r_out_d <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            if (i_tick) begin
                r_hist <= w_hist_next;
                if (&w_hist_next) begin
                    r_out <= 1'b1;
                end else if (~|w_hist_next) begin
                    r_out <= 1'b0;
                end
            end
            r_out_d <= r_out;
            r_rise  <= r_out & ~r_out_d;
            r_fall  <= ~r_out & r_out_d;
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/debounce_event.sv
// Multi-channel button/switch conditioner with sticky edge capture and masked interrupt.
module debounce_event
    import debounce_event_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RATE        = 125000,
    parameter int unsigned N           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic [WIDTH-1:0] event_status,
    input  logic [WIDTH-1:0] event_clear,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    localparam int unsigned          CNT_W    = cnt_width(RATE);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(RATE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [WIDTH-1:0] r_event_status;
    logic             r_irq;

    assign w_tick = (r_cnt == CNT_LAST);

    // Shared sample tick: one cycle in every RATE (every cycle when RATE is 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_event_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .N           (N)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_tick (w_tick),
            .i_in   (in[g]),
            .o_out  (out[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g])
        );
    end

    // Sticky capture of enabled edges; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_event_status <= '0;
        end else begin
            r_event_status <= (r_event_status & ~event_clear)
                            | (rise & rise_en)
                            | (fall & fall_en);
        end
    end

    // Interrupt follows the masked status one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_event_status & irq_mask);
        end
    end

    assign event_status = r_event_status;
    assign irq          = r_irq;

endmodule

// File: tb/tb_debounce_event.sv
// Bench for debounce_event: directed scenarios then random traffic against a run-length model.
module tb_debounce_event;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned RATE  = 4;
    localparam int unsigned NS    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_v, rise_en, fall_en, ev_clr, mask;
    logic [WIDTH-1:0] out, rise, fall, event_status;
    logic             irq;

    int total = 0;
    int bad   = 0;

    // Reference state: level, last-cycle level, pulses, status, irq.
    logic [WIDTH-1:0] m_out, m_last, m_rise, m_fall, m_evt;
    logic             m_irq;
    logic [WIDTH-1:0] m_q[$];
    logic             m_runval[WIDTH];
    int unsigned      m_run[WIDTH];
    int unsigned      m_edge;

    always #5 clk = ~clk;

    debounce_event #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .RATE        (RATE),
        .N           (NS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in_v),
        .out          (out),
        .rise         (rise),
        .fall         (fall),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .event_status (event_status),
        .event_clear  (ev_clr),
        .irq_mask     (mask),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        logic [WIDTH-1:0] s, n_out;
        if (rst) begin
            m_out = '0; m_last = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
            m_q = {};
            repeat (SYNC) m_q.push_back('0);
            for (int unsigned b = 0; b < WIDTH; b++) begin
                m_runval[b] = 1'b0;
                m_run[b]    = 0;
            end
            m_edge = 0;
        end else begin
            m_irq = |(m_evt & mask);
            m_evt = (m_evt & ~ev_clr) | (m_rise & rise_en) | (m_fall & fall_en);
            m_rise = m_out & ~m_last;
            m_fall = ~m_out & m_last;
            s = m_q.pop_front();
            m_q.push_back(in_v);
            n_out = m_out;
            if ((m_edge % RATE) == RATE - 1) begin
                for (int unsigned b = 0; b < WIDTH; b++) begin
                    if (m_run[b] != 0 && s[b] == m_runval[b]) begin
                        m_run[b]++;
                    end else begin
                        m_runval[b] = s[b];
                        m_run[b]    = 1;
                    end
                    if (m_run[b] >= NS) n_out[b] = m_runval[b];
                end
            end
            m_last = m_out;
            m_out  = n_out;
            m_edge++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("out", 32'(out), 32'(m_out));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
        check("event_status", 32'(event_status), 32'(m_evt));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step();
    endtask

    initial begin
        int first;
        int rise_cycles;

        rst = 1'b1; in_v = 8'hFF; rise_en = '0; fall_en = '0; ev_clr = '0; mask = '0;

        // Reset defaults, then release with all inputs high.
        steps(5);
        rst = 1'b0;
        first = 0; rise_cycles = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (out === 8'hFF && first == 0) first = c;
            if (rise === 8'hFF) rise_cycles++;
        end
        check("t1_first_out_lo", 32'(first >= 10), 32'd1);
        check("t1_first_out_hi", 32'(first <= 15), 32'd1);
        check("t1_rise_cycles", 32'(rise_cycles), 32'd1);

        // Glitch rejection: settle low, then a 7-cycle high glitch on bit 0.
        in_v = 8'h00; steps(20);
        rise_en = 8'hFF;
        in_v = 8'h01; steps(7);
        in_v = 8'h00; steps(20);
        check("t2_evt_zero", 32'(event_status), 32'd0);

        // Capture, irq, clear.
        rise_en = 8'h01; mask = 8'h01;
        in_v = 8'h01; steps(20);
        check("t3_evt_set", 32'(event_status), 32'h01);
        ev_clr = 8'h01; step();
        ev_clr = 8'h00; steps(3);
        check("t3_irq_clear", 32'(irq), 32'd0);

        // Set/clear collision with clear held throughout.
        in_v = 8'h00; steps(20);
        ev_clr = 8'h01; in_v = 8'h01; steps(20);
        ev_clr = 8'h00; steps(2);

        // Fall-only enable on bit 7.
        rise_en = 8'h00; fall_en = 8'h80; ev_clr = 8'hFF; step(); ev_clr = 8'h00;
        in_v = 8'h80; steps(20);
        check("t5_no_rise_status", 32'(event_status), 32'd0);
        in_v = 8'h00; steps(20);
        check("t5_fall_status", 32'(event_status), 32'h80);
        ev_clr = 8'hFF; step(); ev_clr = 8'h00;

        // Reset mid-debounce on bit 3.
        in_v = 8'h08; steps(9);
        rst = 1'b1; step(); rst = 1'b0;
        first = 0; rise_cycles = 0;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (out[3] === 1'b1 && first == 0) first = c;
            if (rise[3] === 1'b1) rise_cycles++;
        end
        check("t6_hold_lo", 32'(first >= 10), 32'd1);
        check("t6_rise_hi", 32'(first <= 15), 32'd1);
        check("t6_rise_once", 32'(rise_cycles), 32'd1);

        // Random traffic: slowly toggling inputs with glitches, shifting enables/masks/clears.
        for (int c = 0; c < 1200; c++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(0, 39) == 0) in_v[b] = ~in_v[b];
            end
            if ($urandom_range(0, 49) == 0) begin
                rise_en = 8'($urandom); fall_en = 8'($urandom); mask = 8'($urandom);
            end
            ev_clr = 8'($urandom & $urandom & $urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
